// File: rtl/pool_window_scheduler_pkg.sv
// Shared definitions for the 3x3 max-pool window scheduler: FSM encoding,
// window geometry constants and the job configuration legality check.
package pool_window_scheduler_pkg;

  localparam int WIN_SIZE  = 3;
  localparam int WIN_ELEMS = 9;
  localparam int MIN_DIM   = 3;
  localparam int MAX_DIM   = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  // A job needs a map that fits at least one window, stays within the
  // supported map size and uses a non-zero stride.
  function automatic logic cfg_ok(input int w, input int h, input logic [1:0] s);
    return (w >= MIN_DIM) && (h >= MIN_DIM) &&
           (w <= MAX_DIM) && (h <= MAX_DIM) && (s != 2'd0);
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window/tap position counters for the pool scheduler. Produces source read
// addresses and result indices using running sums only (no divide).
module pool_addr_gen
  import pool_window_scheduler_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_init,
  input  logic              tap_step,
  input  logic              win_step,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [1:0]        cfg_stride,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              tap_last,
  output logic              win_last
);

  localparam int PW = DIM_W + 3;
  localparam logic [1:0] K_LAST = 2'(WIN_SIZE - 1);

  logic [DIM_W-1:0]  width_q;
  logic [DIM_W-1:0]  height_q;
  logic [1:0]        stride_q;
  logic [ADDR_W-1:0] row_step;

  logic [DIM_W-1:0]  ox;
  logic [DIM_W-1:0]  oy;
  logic [1:0]        kx;
  logic [1:0]        ky;
  logic [ADDR_W-1:0] tap_row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] win_base;
  logic [ADDR_W-1:0] oidx;

  logic [PW-1:0]     col_end;
  logic [PW-1:0]     row_end;
  logic              last_col;
  logic              last_row;

  // Stride is at most 3, so scaling by it is a shift-and-add.
  function automatic logic [PW-1:0] scale(input logic [DIM_W-1:0] v, input logic [1:0] s);
    return (s[0] ? PW'(v) : '0) + (s[1] ? (PW'(v) << 1) : '0);
  endfunction

  // A window is the last in its row/column when the next one would overhang the map.
  assign col_end  = scale(ox, stride_q) + PW'(stride_q) + PW'(WIN_SIZE);
  assign row_end  = scale(oy, stride_q) + PW'(stride_q) + PW'(WIN_SIZE);
  assign last_col = col_end > PW'(width_q);
  assign last_row = row_end > PW'(height_q);

  assign tap_last = (kx == K_LAST) && (ky == K_LAST);
  assign win_last = last_col && last_row;
  assign rd_addr  = win_base + tap_row + ADDR_W'(kx);
  assign wr_addr  = oidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q  <= '0;
      height_q <= '0;
      stride_q <= '0;
      row_step <= '0;
    end else if (job_init) begin
      width_q  <= cfg_width;
      height_q <= cfg_height;
      stride_q <= cfg_stride;
      row_step <= ADDR_W'(scale(cfg_width, cfg_stride));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx      <= '0;
      ky      <= '0;
      tap_row <= '0;
    end else if (job_init) begin
      kx      <= '0;
      ky      <= '0;
      tap_row <= '0;
    end else if (tap_step) begin
      if (kx == K_LAST) begin
        kx <= '0;
        if (ky == K_LAST) begin
          ky      <= '0;
          tap_row <= '0;
        end else begin
          ky      <= ky + 2'd1;
          tap_row <= tap_row + ADDR_W'(width_q);
        end
      end else begin
        kx <= kx + 2'd1;
      end
    end
  end

  // win_base tracks the top-left source address of the current window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox       <= '0;
      oy       <= '0;
      row_base <= '0;
      win_base <= '0;
      oidx     <= '0;
    end else if (job_init) begin
      ox       <= '0;
      oy       <= '0;
      row_base <= '0;
      win_base <= '0;
      oidx     <= '0;
    end else if (win_step) begin
      oidx <= oidx + 1'b1;
      if (last_col) begin
        ox       <= '0;
        oy       <= oy + 1'b1;
        row_base <= row_base + row_step;
        win_base <= row_base + row_step;
      end else begin
        ox       <= ox + 1'b1;
        win_base <= win_base + ADDR_W'(stride_q);
      end
    end
  end

endmodule

// File: rtl/pool_window_scheduler.sv
// Walks 3x3 windows over a feature map: fetches 9 taps, hands the window to
// an external max-pooler, and writes each result in raster order.
module pool_window_scheduler
  import pool_window_scheduler_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DIM_W        = 7,
  parameter int POOL_LAT_MAX = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DIM_W-1:0]         cfg_width,
  input  logic [DIM_W-1:0]         cfg_height,
  input  logic [1:0]               cfg_stride,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [7:0]        rd_data,
  output logic                     pool_valid_in,
  output logic [8*WIN_ELEMS-1:0]   pool_win,
  input  logic signed [7:0]        pool_max,
  input  logic                     pool_valid_out,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [7:0]        wr_data
);

  localparam int WCNT_W = $clog2(POOL_LAT_MAX + 2);

  state_t            state;
  state_t            state_nxt;
  logic              job_init;
  logic              tap_step;
  logic              win_step;
  logic              tap_last;
  logic              win_last;
  logic              err_set;
  logic              res_load;
  logic              start_ok;
  logic              rd_pending;
  logic              err_q;
  logic [WCNT_W-1:0] wait_cnt;
  logic [3:0]        slot_ptr;
  logic [7:0]        win_q [WIN_ELEMS];
  logic signed [7:0] res_q;

  assign start_ok = cfg_ok(int'(cfg_width), int'(cfg_height), cfg_stride);

  pool_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .job_init   (job_init),
    .tap_step   (tap_step),
    .win_step   (win_step),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_stride (cfg_stride),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .tap_last   (tap_last),
    .win_last   (win_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      err_q    <= 1'b0;
      wait_cnt <= '0;
      res_q    <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_set;
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (res_load) begin
        res_q <= pool_max;
      end
    end
  end

  // Read data lags rd_en by one cycle, so slot k fills the cycle after read k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WIN_ELEMS; k++) begin
        win_q[k] <= '0;
      end
      slot_ptr   <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= rd_en;
      if (rd_pending) begin
        win_q[slot_ptr] <= rd_data;
        slot_ptr        <= slot_ptr + 4'd1;
      end else begin
        slot_ptr <= '0;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    rd_en         = 1'b0;
    pool_valid_in = 1'b0;
    wr_en         = 1'b0;
    job_init      = 1'b0;
    tap_step      = 1'b0;
    win_step      = 1'b0;
    err_set       = 1'b0;
    res_load      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (start_ok) begin
            job_init  = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        rd_en    = 1'b1;
        tap_step = 1'b1;
        if (tap_last) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_nxt = ST_ISSUE;
      end
      // A zero-latency pooler answers in ISSUE itself and WAIT is skipped.
      ST_ISSUE: begin
        pool_valid_in = 1'b1;
        if (pool_valid_out) begin
          res_load  = 1'b1;
          state_nxt = ST_WRITE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pool_valid_out) begin
          res_load  = 1'b1;
          state_nxt = ST_WRITE;
        end else if (wait_cnt == WCNT_W'(POOL_LAT_MAX)) begin
          err_set   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wr_en     = 1'b1;
        win_step  = 1'b1;
        state_nxt = win_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pool_win = '0;
    for (int k = 0; k < WIN_ELEMS; k++) begin
      pool_win[8*k +: 8] = win_q[k];
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign err     = err_q;
  assign wr_data = res_q;

endmodule

// File: tb/tb_pool_window_scheduler.sv
// Directed bench for pool_window_scheduler: memory and pooler models plus a
// scoreboard of expected read addresses and result writes.
module tb_pool_window_scheduler;

  localparam int ADDR_W       = 12;
  localparam int DIM_W        = 7;
  localparam int POOL_LAT_MAX = 15;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [DIM_W-1:0]         cfg_width = '0;
  logic [DIM_W-1:0]         cfg_height = '0;
  logic [1:0]               cfg_stride = '0;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [7:0]        rd_data = '0;
  logic                     pool_valid_in;
  logic [71:0]              pool_win;
  logic signed [7:0]        pool_max;
  logic                     pool_valid_out;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [7:0]        wr_data;

  logic signed [7:0] mem [0:4095];
  int rd_q[$];
  int wr_addr_q[$];
  int wr_data_q[$];
  int n_checks = 0;
  int n_errs = 0;
  int err_seen = 0;
  int done_seen = 0;

  int                pool_lat = 1;
  bit                pooler_on = 1'b1;
  bit                pool_zero = 1'b0;
  logic              pvo_reg = 1'b0;
  logic signed [7:0] pmax_reg = '0;
  int                pcnt = 0;

  always #5 clk = ~clk;

  pool_window_scheduler #(
    .ADDR_W       (ADDR_W),
    .DIM_W        (DIM_W),
    .POOL_LAT_MAX (POOL_LAT_MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .cfg_stride     (cfg_stride),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .pool_valid_in  (pool_valid_in),
    .pool_win       (pool_win),
    .pool_max       (pool_max),
    .pool_valid_out (pool_valid_out),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data)
  );

  function automatic int winMax(input logic [71:0] w);
    int m;
    int v;
    m = -128;
    for (int k = 0; k < 9; k++) begin
      v = $signed(w[8*k +: 8]);
      if (v > m) m = v;
    end
    return m;
  endfunction

  // Source memory: data valid one cycle after rd_en.
  always @(posedge clk) begin
    rd_data <= rd_en ? mem[rd_addr] : 8'sd0;
  end

  // Pooler with programmable latency (pool_zero answers in the same cycle).
  always @(posedge clk) begin
    if (pool_valid_in && pooler_on && !pool_zero) begin
      pmax_reg <= 8'(winMax(pool_win));
      pcnt     <= pool_lat;
      pvo_reg  <= (pool_lat == 1);
    end else if (pcnt > 1) begin
      pcnt    <= pcnt - 1;
      pvo_reg <= (pcnt == 2);
    end else begin
      pcnt    <= 0;
      pvo_reg <= 1'b0;
    end
  end

  assign pool_valid_out = pool_zero ? (pool_valid_in && pooler_on) : pvo_reg;
  assign pool_max       = pool_zero ? 8'(winMax(pool_win)) : pmax_reg;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: expected reads and results for one job.
  task automatic pushModel(input int w, input int h, input int s, input bit with_writes);
    int ow;
    int oh;
    int a;
    int v;
    int m;
    ow = (w - 3) / s + 1;
    oh = (h - 3) / s + 1;
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        m = -128;
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            a = (oy * s + ky) * w + (ox * s + kx);
            rd_q.push_back(a);
            v = mem[a];
            if (v > m) m = v;
          end
        end
        if (with_writes) begin
          wr_addr_q.push_back(oy * ow + ox);
          wr_data_q.push_back(m);
        end
      end
    end
  endtask

  // Pulses start for one cycle; returns at the negedge of the cycle after it.
  task automatic applyStimulus(input int w, input int h, input int s,
                               input bit model_rd, input bit model_wr);
    @(negedge clk);
    cfg_width  = DIM_W'(w);
    cfg_height = DIM_W'(h);
    cfg_stride = 2'(s);
    start      = 1'b1;
    if (model_rd) pushModel(w, h, s, model_wr);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitSignal(input bit want_err, input int cyc0, input int budget, output int cyc);
    cyc = cyc0;
    while (!(want_err ? err : done) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!(want_err ? err : done)) cyc = -1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    int e;
    if (rst_n) begin
      if (rd_en || pool_valid_in || wr_en)
        checkOutput("strobe_exclusive", 32'(int'(rd_en) + int'(pool_valid_in) + int'(wr_en)), 32'd1);
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          checkOutput("rd_unexpected", 32'(rd_en), 32'd0);
        end else begin
          e = rd_q.pop_front();
          checkOutput("rd_addr", 32'(rd_addr), 32'(e));
        end
      end
      if (wr_en) begin
        if (wr_addr_q.size() == 0) begin
          checkOutput("wr_unexpected", 32'(wr_en), 32'd0);
        end else begin
          e = wr_addr_q.pop_front();
          checkOutput("wr_addr", 32'(wr_addr), 32'(e));
          e = wr_data_q.pop_front();
          checkOutput("wr_data", 32'(int'(wr_data)), 32'(e));
        end
      end
      if (err) err_seen++;
      if (done) done_seen++;
    end
  end

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    checkOutput({tag, "_wr_left"}, 32'(wr_addr_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    int e0;
    int d0;

    for (int i = 0; i < 4096; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("rst_pool_valid_in", 32'(pool_valid_in), 32'd0);
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_pool_win_nz", 32'(|pool_win), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] job A: 4x4 stride 1");
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    e0 = err_seen;
    applyStimulus(4, 4, 1, 1'b1, 1'b1);
    checkOutput("A_busy", 32'(busy), 32'd1);
    waitSignal(1'b0, 1, 200, cyc);
    checkOutput("A_done_cycle", 32'(cyc), 32'd53);
    @(negedge clk);
    checkOutput("A_busy_after", 32'(busy), 32'd0);
    checkDrained("A");
    checkOutput("A_no_err", 32'(err_seen - e0), 32'd0);

    $display("[TB] job B: 5x5 stride 2, negative data");
    for (int i = 0; i < 25; i++) mem[i] = 8'(-i);
    applyStimulus(5, 5, 2, 1'b1, 1'b1);
    waitSignal(1'b0, 1, 200, cyc);
    checkOutput("B_done_cycle", 32'(cyc), 32'd53);
    @(negedge clk);
    checkDrained("B");

    $display("[TB] rejected starts");
    d0 = done_seen;
    applyStimulus(2, 5, 1, 1'b0, 1'b0);
    waitSignal(1'b1, 1, 5, cyc);
    checkOutput("rej_w2_err_cycle", 32'(cyc), 32'd1);
    checkOutput("rej_w2_busy", 32'(busy), 32'd0);
    applyStimulus(5, 5, 0, 1'b0, 1'b0);
    waitSignal(1'b1, 1, 5, cyc);
    checkOutput("rej_s0_err_cycle", 32'(cyc), 32'd1);
    checkOutput("rej_s0_busy", 32'(busy), 32'd0);
    applyStimulus(65, 3, 1, 1'b0, 1'b0);
    waitSignal(1'b1, 1, 5, cyc);
    checkOutput("rej_w65_err_cycle", 32'(cyc), 32'd1);
    @(negedge clk);
    checkOutput("rej_busy_after", 32'(busy), 32'd0);
    checkOutput("rej_no_done", 32'(done_seen - d0), 32'd0);

    $display("[TB] job C: 64x3 stride 3, random data");
    for (int i = 0; i < 192; i++) mem[i] = 8'($urandom_range(0, 255));
    applyStimulus(64, 3, 3, 1'b1, 1'b1);
    waitSignal(1'b0, 1, 400, cyc);
    checkOutput("C_done_cycle", 32'(cyc), 32'd274);
    @(negedge clk);
    checkDrained("C");

    $display("[TB] job A with a stray start during FETCH");
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    e0 = err_seen;
    applyStimulus(4, 4, 1, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    cfg_width  = 7'd3;
    cfg_height = 7'd3;
    cfg_stride = 2'd1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitSignal(1'b0, 4, 200, cyc);
    checkOutput("stray_done_cycle", 32'(cyc), 32'd53);
    @(negedge clk);
    checkDrained("stray");
    checkOutput("stray_no_err", 32'(err_seen - e0), 32'd0);

    $display("[TB] reset during FETCH");
    applyStimulus(4, 4, 1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("mid_rd_en_before_rst", 32'(rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("mid_rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("mid_rst_pool_win_nz", 32'(|pool_win), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    rd_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) mem[i] = 8'(i * 7 - 30);
    applyStimulus(3, 3, 1, 1'b1, 1'b1);
    waitSignal(1'b0, 1, 100, cyc);
    checkOutput("post_rst_done_cycle", 32'(cyc), 32'd14);
    @(negedge clk);
    checkDrained("post_rst");

    $display("[TB] zero-latency pooler");
    pool_zero = 1'b1;
    applyStimulus(3, 3, 1, 1'b1, 1'b1);
    waitSignal(1'b0, 1, 100, cyc);
    checkOutput("zero_lat_done_cycle", 32'(cyc), 32'd13);
    @(negedge clk);
    pool_zero = 1'b0;
    checkDrained("zero_lat");

    $display("[TB] pooler at maximum latency");
    pool_lat = POOL_LAT_MAX;
    e0 = err_seen;
    applyStimulus(3, 3, 1, 1'b1, 1'b1);
    waitSignal(1'b0, 1, 100, cyc);
    checkOutput("max_lat_done_cycle", 32'(cyc), 32'd28);
    @(negedge clk);
    checkDrained("max_lat");
    checkOutput("max_lat_no_err", 32'(err_seen - e0), 32'd0);
    pool_lat = 1;

    $display("[TB] pooler never answers");
    pooler_on = 1'b0;
    d0 = done_seen;
    applyStimulus(3, 3, 1, 1'b1, 1'b0);
    waitSignal(1'b1, 1, 100, cyc);
    checkOutput("timeout_err_cycle", 32'(cyc), 32'd28);
    checkOutput("timeout_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("timeout_no_done", 32'(done_seen - d0), 32'd0);
    checkDrained("timeout");
    pooler_on = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
